// File: rtl/jtframe_romarb_pkg.sv
// Shared types, bus widths and the offset helper for the SDRAM ROM-slot arbiter.
package jtframe_romarb_pkg;

  localparam int SDRAM_AW = 22;
  localparam int SDRAM_DW = 16;
  localparam int MAXSLOT  = 16;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DST, WAIT_RDY} state_t;

  // Word offset of slot i within a MAXSLOT-wide flattened offset vector.
  function automatic logic [SDRAM_AW-1:0] slot_offset(
    input logic [MAXSLOT*SDRAM_AW-1:0] offsets,
    input int                          i
  );
    return offsets[i*SDRAM_AW +: SDRAM_AW];
  endfunction

endpackage

// File: rtl/jtframe_romarb_slot.sv
// One client slot: single-word tag/data cache, hit compare, word address and byte select.
module jtframe_romarb_slot
  import jtframe_romarb_pkg::*;
#(
  parameter bit                  DW8    = 1'b0,
  parameter logic [SDRAM_AW-1:0] OFFSET = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_flush,
  input  logic                i_we,
  input  logic [SDRAM_AW-1:0] i_gaddr,
  input  logic [SDRAM_DW-1:0] i_wdata,
  input  logic                i_cs,
  input  logic [SDRAM_AW-1:0] i_addr,
  output logic [SDRAM_AW-1:0] o_waddr,
  output logic [SDRAM_AW-1:0] o_saddr,
  output logic                o_ok,
  output logic [SDRAM_DW-1:0] o_dout
);

  logic [SDRAM_AW-1:0] r_tag;
  logic                r_valid;
  logic [SDRAM_DW-1:0] r_data;

  assign o_waddr = DW8 ? {1'b0, i_addr[SDRAM_AW-1:1]} : i_addr;
  assign o_saddr = o_waddr + OFFSET;
  assign o_ok    = i_cs & r_valid & ~i_flush & (r_tag == o_waddr);

  // Byte lane follows the live address so a neighbouring byte hits immediately.
  always_comb begin
    if (DW8) o_dout = {8'h00, i_addr[0] ? r_data[15:8] : r_data[7:0]};
    else     o_dout = r_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_we) begin
      r_tag   <= i_gaddr;
      r_valid <= 1'b1;
      r_data  <= i_wdata;
    end
  end

endmodule

// File: rtl/jtframe_romarb.sv
// SDRAM ROM-slot arbiter: per-slot one-word caches, misses served one at a time on one read port.
// Define JTFRAME_ROMARB_STATS_EN to build the per-slot saturating miss counters.
module jtframe_romarb
  import jtframe_romarb_pkg::*;
#(
  parameter int                          NSLOT    = 9,
  parameter logic [NSLOT-1:0]            SLOT_DW8 = '0,
  parameter logic [NSLOT*SDRAM_AW-1:0]   OFFSETS  = '0,
  parameter bit                          RR_EN    = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        downloading,
  input  logic [NSLOT-1:0]            slot_cs,
  input  logic [NSLOT*SDRAM_AW-1:0]   slot_addr,
  output logic [NSLOT-1:0]            slot_ok,
  output logic [NSLOT*SDRAM_DW-1:0]   slot_dout,
  output logic                        sdram_req,
  output logic [SDRAM_AW-1:0]         sdram_addr,
  input  logic                        sdram_ack,
  input  logic                        data_dst,
  input  logic                        data_rdy,
  input  logic [SDRAM_DW-1:0]         data_read,
  output logic [NSLOT*16-1:0]         miss_cnt
);

  localparam int GW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int OW = MAXSLOT * SDRAM_AW;
  localparam logic [OW-1:0] OFFS_EXT = OW'(OFFSETS);

  state_t              r_st;
  logic                r_req;
  logic [SDRAM_AW-1:0] r_addr;
  logic [SDRAM_AW-1:0] r_gaddr;
  logic [GW-1:0]       r_gnt;
  logic [GW-1:0]       r_ptr;

  logic [SDRAM_AW-1:0] w_waddr [NSLOT];
  logic [SDRAM_AW-1:0] w_saddr [NSLOT];
  logic [NSLOT-1:0]    w_pend;
  logic [GW-1:0]       w_gnt;
  logic [GW-1:0]       w_ptr_nxt;
  logic                w_fill;
  logic                w_grant;

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    jtframe_romarb_slot #(
      .DW8    (SLOT_DW8[i]),
      .OFFSET (slot_offset(OFFS_EXT, i))
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_flush (downloading),
      .i_we    (w_fill && (r_gnt == GW'(i))),
      .i_gaddr (r_gaddr),
      .i_wdata (data_read),
      .i_cs    (slot_cs[i]),
      .i_addr  (slot_addr[i*SDRAM_AW +: SDRAM_AW]),
      .o_waddr (w_waddr[i]),
      .o_saddr (w_saddr[i]),
      .o_ok    (slot_ok[i]),
      .o_dout  (slot_dout[i*SDRAM_DW +: SDRAM_DW])
    );
    assign w_pend[i] = slot_cs[i] & ~slot_ok[i];
  end

  // First pending slot at or after base, wrapping.
  function automatic logic [GW-1:0] pick(input logic [NSLOT-1:0] pend, input logic [GW-1:0] base);
    int idx;
    pick = '0;
    for (int k = NSLOT - 1; k >= 0; k--) begin
      idx = (int'(base) + k) % NSLOT;
      if (pend[idx]) pick = GW'(idx);
    end
  endfunction

  assign w_gnt     = pick(w_pend, RR_EN ? r_ptr : '0);
  assign w_ptr_nxt = (w_gnt == GW'(NSLOT - 1)) ? '0 : w_gnt + 1'b1;
  assign w_grant   = (r_st == IDLE) && (|w_pend) && !downloading;
  // dst and rdy together in WAIT_DST complete the fill in that same cycle.
  assign w_fill    = !downloading && data_rdy &&
                     ((r_st == WAIT_RDY) || ((r_st == WAIT_DST) && data_dst));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st    <= IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_gaddr <= '0;
      r_gnt   <= '0;
      r_ptr   <= '0;
    end else if (downloading) begin
      r_st  <= IDLE;
      r_req <= 1'b0;
    end else begin
      unique case (r_st)
        IDLE: if (w_grant) begin
          r_gnt   <= w_gnt;
          r_gaddr <= w_waddr[w_gnt];
          r_addr  <= w_saddr[w_gnt];
          r_req   <= 1'b1;
          r_st    <= REQ;
          if (RR_EN) r_ptr <= w_ptr_nxt;
        end
        REQ: if (sdram_ack) begin
          r_req <= 1'b0;
          r_st  <= WAIT_DST;
        end
        WAIT_DST: if (data_dst) r_st <= data_rdy ? IDLE : WAIT_RDY;
        WAIT_RDY: if (data_rdy) r_st <= IDLE;
        default:  r_st <= IDLE;
      endcase
    end
  end

  assign sdram_req  = r_req;
  assign sdram_addr = r_addr;

`ifdef JTFRAME_ROMARB_STATS_EN
  logic [15:0] r_cnt [NSLOT];
  logic        r_dl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dl <= 1'b0;
      for (int i = 0; i < NSLOT; i++) r_cnt[i] <= '0;
    end else begin
      r_dl <= downloading;
      for (int i = 0; i < NSLOT; i++) begin
        if (downloading && !r_dl) begin
          r_cnt[i] <= '0;
        end else if (w_grant && (w_gnt == GW'(i)) && (r_cnt[i] != 16'hFFFF)) begin
          r_cnt[i] <= r_cnt[i] + 16'd1;
        end
      end
    end
  end

  for (genvar i = 0; i < NSLOT; i++) begin : g_cnt
    assign miss_cnt[i*16 +: 16] = r_cnt[i];
  end
`else
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_jtframe_romarb.sv
// Directed bench for jtframe_romarb: a fixed-priority and a round-robin instance share stimulus.
module tb_jtframe_romarb;

  localparam int          NSLOT = 3;
  localparam logic [2:0]  DW8   = 3'b100;
  localparam logic [65:0] OFFS  = {22'h0, 22'h4000, 22'h0};

  logic        clk = 1'b0, rst = 1'b0, downloading = 1'b0;
  logic [2:0]  cs = '0;
  logic [21:0] a0 = '0, a1 = '0, a2 = '0;
  logic        ack = 1'b0, dst = 1'b0, rdy = 1'b0;
  logic [15:0] rdata = '0;

  logic [2:0]  ok0, ok1;
  logic [47:0] dout0, dout1, mc0, mc1;
  logic        req0, req1;
  logic [21:0] sa0, sa1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jtframe_romarb #(.NSLOT(NSLOT), .SLOT_DW8(DW8), .OFFSETS(OFFS), .RR_EN(1'b0)) u_fix (
    .clk(clk), .rst(rst), .downloading(downloading), .slot_cs(cs), .slot_addr({a2, a1, a0}),
    .slot_ok(ok0), .slot_dout(dout0), .sdram_req(req0), .sdram_addr(sa0), .sdram_ack(ack),
    .data_dst(dst), .data_rdy(rdy), .data_read(rdata), .miss_cnt(mc0)
  );

  jtframe_romarb #(.NSLOT(NSLOT), .SLOT_DW8(DW8), .OFFSETS(OFFS), .RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst), .downloading(downloading), .slot_cs(cs), .slot_addr({a2, a1, a0}),
    .slot_ok(ok1), .slot_dout(dout1), .sdram_req(req1), .sdram_addr(sa1), .sdram_ack(ack),
    .data_dst(dst), .data_rdy(rdy), .data_read(rdata), .miss_cnt(mc1)
  );

  typedef struct {
    logic [2:0]  cs;
    logic [21:0] a0, a1, a2;
    logic [2:0]  ok;
    logic [15:0] d0, d1, d2;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic wait_req(output logic [21:0] s0, output logic [21:0] s1);
    int k = 0;
    while (req0 !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk("req_seen", 48'(req0), 48'd1);
    s0 = sa0;
    s1 = sa1;
  endtask

  task automatic finish(input logic [15:0] d, input bit same, input int dly);
    for (int k = 0; k < dly; k++) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    if (same) begin
      dst = 1'b1; rdy = 1'b1; rdata = d;
      step();
      dst = 1'b0; rdy = 1'b0;
    end else begin
      dst = 1'b1;
      step();
      dst = 1'b0; rdy = 1'b1; rdata = d;
      step();
      rdy = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [21:0] s0, s1;
    bit          quiet;

    // slot1 holds BEEF @ word 0x10, slot2 holds 12AB @ word 0x10, slot0 invalid
    vecs[0] = '{cs: 3'b010, a0: 22'h0,  a1: 22'h10, a2: 22'h21, ok: 3'b010,
                d0: 16'h0, d1: 16'hBEEF, d2: 16'h0012};
    vecs[1] = '{cs: 3'b010, a0: 22'h0,  a1: 22'h11, a2: 22'h21, ok: 3'b000,
                d0: 16'h0, d1: 16'hBEEF, d2: 16'h0012};
    vecs[2] = '{cs: 3'b100, a0: 22'h0,  a1: 22'h10, a2: 22'h20, ok: 3'b100,
                d0: 16'h0, d1: 16'hBEEF, d2: 16'h00AB};
    vecs[3] = '{cs: 3'b100, a0: 22'h0,  a1: 22'h10, a2: 22'h22, ok: 3'b000,
                d0: 16'h0, d1: 16'hBEEF, d2: 16'h00AB};
    vecs[4] = '{cs: 3'b111, a0: 22'h10, a1: 22'h10, a2: 22'h21, ok: 3'b110,
                d0: 16'h0, d1: 16'hBEEF, d2: 16'h0012};
    vecs[5] = '{cs: 3'b000, a0: 22'h10, a1: 22'h10, a2: 22'h23, ok: 3'b000,
                d0: 16'h0, d1: 16'hBEEF, d2: 16'h0012};

    // Reset and idle
    rst = 1'b0;
    step();
    step();
    chk("rst_req", 48'(req0), 48'd0);
    chk("rst_ok", 48'(ok0), 48'd0);
    chk("rst_dout", dout0, 48'd0);
    rst = 1'b1;
    step();
    step();
    chk("idle_req", 48'(req0), 48'd0);
    chk("idle_ok", 48'(ok0 | ok1), 48'd0);
    chk("idle_dout", dout1, 48'd0);
    chk("idle_miss_cnt", mc0, 48'd0);

    // Single 16-bit miss then hit
    cs = 3'b010;
    a1 = 22'h10;
    chk("req_before_edge", 48'(req0), 48'd0);
    step();
    chk("req_latency", 48'(req0), 48'd1);
    chk("miss_addr", 48'(sa0), 48'h4010);
    finish(16'hBEEF, 1'b0, 2);
    chk("fill_ok", 48'(ok0[1]), 48'd1);
    chk("fill_dout", 48'(dout0[31:16]), 48'hBEEF);
    quiet = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (req0 !== 1'b0) quiet = 1'b0;
    end
    chk("hit_no_rereq", 48'(quiet), 48'd1);
    cs = 3'b000;
    #1;
    chk("cs_low_ok", 48'(ok0), 48'd0);
    chk("cs_low_dout_hold", 48'(dout0[31:16]), 48'hBEEF);
    step();

    // Byte slot, dst and rdy in the same cycle
    cs = 3'b100;
    a2 = 22'h21;
    wait_req(s0, s1);
    chk("byte_addr", 48'(s0), 48'h10);
    finish(16'h12AB, 1'b1, 0);
    chk("byte_hi_ok", 48'(ok0[2]), 48'd1);
    chk("byte_hi_dout", 48'(dout0[47:32]), 48'h0012);
    a2 = 22'h20;
    #1;
    chk("byte_lo_ok", 48'(ok0[2]), 48'd1);
    chk("byte_lo_dout", 48'(dout0[47:32]), 48'h00AB);
    step();

    // Hit/miss table, all within one clock period
    for (int i = 0; i < 6; i++) begin
      cs = vecs[i].cs; a0 = vecs[i].a0; a1 = vecs[i].a1; a2 = vecs[i].a2;
      #1;
      chk($sformatf("vec%0d_ok", i), 48'(ok0), 48'(vecs[i].ok));
      chk($sformatf("vec%0d_dout", i), dout0, {vecs[i].d2, vecs[i].d1, vecs[i].d0});
    end
    cs = 3'b000;
    step();

    // Download while waiting for data
    a0 = 22'h30;
    a1 = 22'h10;
    cs = 3'b011;
    wait_req(s0, s1);
    chk("dl_miss_addr", 48'(s0), 48'h30);
    ack = 1'b1;
    step();
    ack = 1'b0;
    dst = 1'b1;
    step();
    dst = 1'b0;
    chk("dl_pre_ok", 48'(ok0[1]), 48'd1);
    downloading = 1'b1;
    step();
    chk("dl_req", 48'(req0), 48'd0);
    chk("dl_ok", 48'(ok0), 48'd0);
    rdy = 1'b1;
    rdata = 16'hDEAD;
    step();
    rdy = 1'b0;
    downloading = 1'b0;
    cs = 3'b010;
    step();
    chk("dl_rereq", 48'(req0), 48'd1);
    chk("dl_rereq_addr", 48'(sa0), 48'h4010);
    finish(16'h1111, 1'b0, 0);
    chk("dl_refill", {31'd0, ok0[1], dout0[31:16]}, {31'd0, 1'b1, 16'h1111});
    cs = 3'b000;
    step();

    // Contention between slots 0 and 2, kept missing every grant
    do_reset();
    a0 = 22'h100;
    a2 = 22'h400;
    cs = 3'b101;
    for (int n = 0; n < 6; n++) begin
      wait_req(s0, s1);
      chk($sformatf("fixed_grant%0d", n), 48'(s0), 48'(22'h100 + n));
      chk($sformatf("rr_grant%0d", n), 48'(s1), 48'((n % 2) ? 22'h200 + n : 22'h100 + n));
      a0 = 22'h100 + 22'(n + 1);
      a2 = (22'h200 + 22'(n + 1)) << 1;
      finish(16'(n), 1'b0, 0);
    end
    cs = 3'b000;
    step();

    // Stale fill after address change
    do_reset();
    a0 = 22'h5;
    cs = 3'b001;
    wait_req(s0, s1);
    chk("stale_first_addr", 48'(s0), 48'h5);
    ack = 1'b1;
    step();
    ack = 1'b0;
    dst = 1'b1;
    step();
    dst = 1'b0;
    a0 = 22'h6;
    rdy = 1'b1;
    rdata = 16'h5555;
    step();
    rdy = 1'b0;
    chk("stale_ok", 48'(ok0[0]), 48'd0);
    step();
    chk("stale_rereq", 48'(req0), 48'd1);
    chk("stale_rereq_addr", 48'(sa0), 48'h6);
`ifdef JTFRAME_ROMARB_STATS_EN
    chk("stale_miss_cnt", 48'(mc0[15:0]), 48'd2);
`else
    chk("stale_miss_cnt", mc0, 48'd0);
`endif
    finish(16'h6666, 1'b0, 0);
    chk("stale_refill", {31'd0, ok0[0], dout0[15:0]}, {31'd0, 1'b1, 16'h6666});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/jtframe_romarb.md
Name: jtframe_romarb

Overview:
- Parametrised SDRAM ROM-slot arbiter. It replaces fixed 9-slot ROM muxing in game tops.
- Serves NSLOT read-only clients: CPUs, GFX fetchers and ADPCM.
- Each slot has a one-word tag/data cache. Misses are arbitrated onto the single SDRAM read port using either fixed or round-robin priority.
- Sits between the game cores and the SDRAM controller, in the clk domain.

Parameters:
- NSLOT, 9: number of client slots (1..16).
- SLOT_DW8, 0: bitmask; bit i=1 means slot i is 8-bit (byte address), otherwise 16-bit (word address).
- OFFSETS, 0: flattened NSLOT×22-bit word offsets; slot i occupies bits [22i+21:22i].
- RR_EN, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- downloading  in  1  ROM download in progress.
- slot_cs  in  NSLOT  per-slot request.
- slot_addr  in  22*NSLOT  per-slot address; byte address for 8-bit slots, word address otherwise.
- slot_ok  out  NSLOT  slot_dout valid for the current slot_addr.
- slot_dout  out  16*NSLOT  data; 8-bit slots use bits [7:0] with [15:8]=0.
- sdram_req  out  1  read request.
- sdram_addr  out  22  SDRAM word address.
- sdram_ack  in  1  request accepted.
- data_dst  in  1  data burst start.
- data_rdy  in  1  data_read valid.
- data_read  in  16  SDRAM data.
- miss_cnt  out  16*NSLOT  per-slot miss statistics (see Optional Feature).

Behaviour:
- Reset (rst=0, async) clears:
  - all tag valids, sdram_req, sdram_addr, slot_ok and slot_dout;
  - the round-robin pointer (set to 0);
  - the FSM (to IDLE).
- Word address per slot:
  - 8-bit slot: waddr = slot_addr[21:1].
  - 16-bit slot: waddr = slot_addr.
  - SDRAM address = waddr + OFFSET[i], modulo 2^22 (wrap, no error).
- Hit: slot_ok[i] = slot_cs[i] & valid[i] & (tag[i]==waddr). This is combinational from registered tag/valid. With cs low, ok=0 and dout holds its last value.
- Byte select for 8-bit slots: slot_addr[0]=0 → data[7:0]; 1 → data[15:8]. Selection uses the live address.
- Miss: pending[i] = slot_cs[i] & ~hit[i], evaluated combinationally each cycle.
- FSM states: IDLE, REQ, WAIT_DST, WAIT_RDY.
  - IDLE: if any pending slot and !downloading, grant g, latch gaddr = waddr_g, assert sdram_req, go to REQ next edge.
    - Fixed priority: g = lowest pending index.
    - Round-robin: g = first pending index at or after ptr, wrapping; ptr ← g+1 mod NSLOT on grant.
  - REQ: hold sdram_req and sdram_addr stable until sdram_ack. On sdram_ack, drop sdram_req and go to WAIT_DST.
  - WAIT_DST: on data_dst, go to WAIT_RDY. If data_dst and data_rdy arrive in the same cycle, treat as WAIT_RDY completion in that cycle.
  - WAIT_RDY: on data_rdy, write data_read to data[g], set tag[g]=gaddr and valid[g]=1, go to IDLE.
- Latency: a miss presented at edge 0 with the FSM idle gives sdram_req=1 after edge 1. slot_ok rises the cycle after the data_rdy edge. Minimum miss latency = 3 + SDRAM latency cycles. Hit latency is 0.
- Client address changes while its request is in flight: fill still completes with the old tag. The next compare misses and re-requests. No abort.
- slot_cs dropped mid-flight: fill completes anyway.
- downloading=1:
  - all valid bits clear on every cycle;
  - sdram_req forced 0 and the FSM forced to IDLE on the next edge, including mid-transaction;
  - slot_ok=0.
- Only one outstanding SDRAM transaction at any time.

Optional Feature:
- JTFRAME_ROMARB_STATS_EN defined: miss_cnt[i] is a 16-bit saturating counter (stops at 16'hFFFF).
  - Increments on each grant to slot i.
  - Cleared by reset and by a rising edge of downloading.
- Undefined: no counters are built and miss_cnt is tied to 0.

Decomposition:
- Package jtframe_romarb_pkg holds:
  - FSM state enum (IDLE, REQ, WAIT_DST, WAIT_RDY);
  - SDRAM_AW=22, SDRAM_DW=16, MAXSLOT=16;
  - a function slot_offset(OFFSETS, i).
- Sub-module jtframe_romarb_slot (one per slot via generate):
  - holds tag/valid/data registers, hit compare, byte select and waddr;
  - ports: write strobe, gaddr, wdata, flush.
- The top holds the arbiter, FSM and stats.

Test Plan:
- Reset/idle: NSLOT=3, rst=0 then 1, no cs → sdram_req=0, slot_ok=0, all slot_dout=0.
- Single miss then hit: slot1 16-bit, OFFSET1=22'h4000, addr=22'h10; ack 2 cycles later, data_rdy with 16'hBEEF.
  - sdram_req rises 1 cycle after cs.
  - sdram_addr=22'h4010.
  - slot_ok[1]=1 with dout=BEEF the cycle after data_rdy.
  - A repeat read hits with no new sdram_req.
- Byte select: slot2 8-bit, addr=22'h21; data_read=16'h12AB.
  - dout=16'h0012.
  - Changing addr to 22'h20 gives an immediate hit with dout=16'h00AB.
- Contention: slots 0 and 2 both miss every cycle for 6 grants.
  - RR_EN=0: grant order 0,0,0…; slot 2 starves while slot 0 keeps missing.
  - RR_EN=1: grant order 0,2,0,2.
- Download mid-flight: downloading=1 while in WAIT_RDY.
  - Next cycle: FSM in IDLE, sdram_req=0, all slot_ok=0.
  - After downloading falls, a previously cached address misses and re-requests.
- Stale fill: slot0 addr changes from 5 to 6 before data_rdy.
  - Fill tags 5; ok stays 0; a new request goes out for 6.
  - With STATS_EN, miss_cnt[0]=2.
